// File: rtl/uart_doc_sender.sv
`default_nettype none
// ============================================================================
// Module   : uart_doc_sender
// Purpose  : Streams the text document over a UART TX line (8N1, LSB first).
//            While a dump is running this block owns the document RAM read
//            port. It visits every visible cell row by row, turns empty cells
//            (8'h00) into spaces, ends each row with CR LF, and then pulses
//            done.
// Revision : 1.0 - initial release
// ============================================================================
module uart_doc_sender #(
    parameter int BAUD_DIV = 868,  // clk cycles per UART bit
    parameter int ROWS     = 15,   // document rows transmitted
    parameter int COLS     = 20    // cells per row transmitted
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       read_enable,
    output logic [8:0] read_addr,
    input  logic [7:0] read_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [4:0]       c_COL_LAST   = 5'(COLS - 1);
    localparam logic [3:0]       c_ROW_LAST   = 4'(ROWS - 1);
    localparam logic [3:0]       c_BIT_LAST   = 4'd9;   // stop bit of a 10-bit frame
    localparam logic [7:0]       c_CHAR_CR    = 8'h0D;
    localparam logic [7:0]       c_CHAR_LF    = 8'h0A;
    localparam logic [7:0]       c_CHAR_SPACE = 8'h20;

    // State encoding
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_SEND  = 3'd2;
    localparam logic [2:0] c_ST_CR    = 3'd3;
    localparam logic [2:0] c_ST_LF    = 3'd4;
    localparam logic [2:0] c_ST_FIN   = 3'd5;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [3:0]         r_row;
    logic [4:0]         r_col;
    logic [c_CNT_W-1:0] r_baud_cnt;
    logic [3:0]         r_bit_idx;
    // r_frame[0] is always the bit currently driven on tx. After each bit
    // the frame shifts right and a 1 fills in from the top, so an idle-high
    // line is left behind once the frame has finished.
    logic [9:0]         r_frame;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_bit_end;
    logic       w_frame_last_bit;
    logic [7:0] w_cell_byte;

    assign w_bit_end        = (r_baud_cnt == c_BAUD_LAST);
    assign w_frame_last_bit = (r_bit_idx == c_BIT_LAST);
    // An empty cell goes out as a space so that the terminal keeps each column aligned
    assign w_cell_byte      = (read_data == 8'h00) ? c_CHAR_SPACE : read_data;

    // Build an 8N1 frame: {stop, data, start}. The start bit sits at bit 0.
    function automatic logic [9:0] f_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

    // Dump sequencer, UART bit timing, and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_row       <= 4'd0;
            r_col       <= 5'd0;
            r_baud_cnt  <= '0;
            r_bit_idx   <= 4'd0;
            r_frame     <= '1;
            tx          <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            read_enable <= 1'b0;
            read_addr   <= 9'd0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_state     <= c_ST_FETCH;
                        r_row       <= 4'd0;
                        r_col       <= 5'd0;
                        busy        <= 1'b1;
                        read_enable <= 1'b1;
                        read_addr   <= 9'd0;
                    end
                end

                // read_addr was set up on the way in. Because the RAM read is
                // asynchronous, read_data is valid by the end of this cycle.
                c_ST_FETCH: begin
                    r_frame    <= f_frame(w_cell_byte);
                    tx         <= 1'b0;
                    r_baud_cnt <= '0;
                    r_bit_idx  <= 4'd0;
                    r_state    <= c_ST_SEND;
                end

                // Cell, CR and LF frames share the same bit timing. They
                // differ only in what follows the stop bit.
                c_ST_SEND, c_ST_CR, c_ST_LF: begin
                    if (!w_bit_end) begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end else begin
                        r_baud_cnt <= '0;
                        if (!w_frame_last_bit) begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_frame   <= {1'b1, r_frame[9:1]};
                            tx        <= r_frame[1];
                        end else begin
                            r_bit_idx <= 4'd0;
                            if (r_state == c_ST_SEND) begin
                                if (r_col != c_COL_LAST) begin
                                    r_col     <= r_col + 5'd1;
                                    read_addr <= {r_row, r_col + 5'd1};
                                    r_state   <= c_ST_FETCH;
                                end else begin
                                    // The CR start bit follows the stop bit with no gap
                                    r_col   <= 5'd0;
                                    r_frame <= f_frame(c_CHAR_CR);
                                    tx      <= 1'b0;
                                    r_state <= c_ST_CR;
                                end
                            end else if (r_state == c_ST_CR) begin
                                r_frame <= f_frame(c_CHAR_LF);
                                tx      <= 1'b0;
                                r_state <= c_ST_LF;
                            end else begin
                                if (r_row != c_ROW_LAST) begin
                                    r_row     <= r_row + 4'd1;
                                    read_addr <= {r_row + 4'd1, 5'd0};
                                    r_state   <= c_ST_FETCH;
                                end else begin
                                    // Done is raised, and the RAM port released, while in FIN
                                    done        <= 1'b1;
                                    busy        <= 1'b0;
                                    read_enable <= 1'b0;
                                    r_state     <= c_ST_FIN;
                                end
                            end
                        end
                    end
                end

                c_ST_FIN: begin
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_doc_sender.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_doc_sender
// Purpose  : Directed self-checking bench for uart_doc_sender. It uses four
//            instances: a tiny 1x2 document, a 2x3 document, the full 15x20
//            document at a short baud divisor, and one instance with default
//            parameters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_doc_sender;

    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_v [NDUT];
    logic       re_v    [NDUT];
    logic [8:0] addr_v  [NDUT];
    logic [7:0] rdata_v [NDUT];
    logic       tx_v    [NDUT];
    logic       busy_v  [NDUT];
    logic       done_v  [NDUT];
    logic [7:0] doc     [NDUT][512];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    uart_doc_sender #(.BAUD_DIV(4), .ROWS(1), .COLS(2)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .read_enable(re_v[0]),
        .read_addr(addr_v[0]), .read_data(rdata_v[0]), .tx(tx_v[0]),
        .busy(busy_v[0]), .done(done_v[0]));

    uart_doc_sender #(.BAUD_DIV(4), .ROWS(2), .COLS(3)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .read_enable(re_v[1]),
        .read_addr(addr_v[1]), .read_data(rdata_v[1]), .tx(tx_v[1]),
        .busy(busy_v[1]), .done(done_v[1]));

    uart_doc_sender #(.BAUD_DIV(4), .ROWS(15), .COLS(20)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .read_enable(re_v[2]),
        .read_addr(addr_v[2]), .read_data(rdata_v[2]), .tx(tx_v[2]),
        .busy(busy_v[2]), .done(done_v[2]));

    uart_doc_sender u_d (
        .clk(clk), .rst(rst), .start(start_v[3]), .read_enable(re_v[3]),
        .read_addr(addr_v[3]), .read_data(rdata_v[3]), .tx(tx_v[3]),
        .busy(busy_v[3]), .done(done_v[3]));

    // Document RAM models: combinational read
    always_comb begin
        for (int d = 0; d < NDUT; d++) rdata_v[d] = doc[d][addr_v[d]];
    end

    function automatic int baud_of(input int d);
        return (d == 3) ? 868 : 4;
    endfunction

    // ------------------------------------------------------------------------
    // Per-instance UART receivers, done-pulse counters and an address logger
    // ------------------------------------------------------------------------
    logic       dec_act   [NDUT] = '{default: 1'b0};
    int         dec_cnt   [NDUT] = '{default: 0};
    logic [7:0] dec_sh    [NDUT] = '{default: 8'h00};
    logic [7:0] rx        [NDUT][400];
    int         rx_n      [NDUT] = '{default: 0};
    int         frame_err [NDUT] = '{default: 0};
    int         done_n    [NDUT] = '{default: 0};
    logic [8:0] adr_log   [16];
    int         adr_n     = 0;
    logic       re_prev   = 1'b0;
    logic [8:0] adr_prev  = 9'd0;

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (done_v[d] === 1'b1) done_n[d] <= done_n[d] + 1;
            if (rst) begin
                dec_act[d] <= 1'b0;
                dec_cnt[d] <= 0;
            end else if (!dec_act[d]) begin
                if (tx_v[d] === 1'b0) begin
                    dec_act[d] <= 1'b1;
                    dec_cnt[d] <= 1;
                end
            end else begin
                dec_cnt[d] <= dec_cnt[d] + 1;
                if ((dec_cnt[d] % baud_of(d)) == baud_of(d) / 2) begin
                    if (dec_cnt[d] < baud_of(d)) begin
                        if (tx_v[d] !== 1'b0) frame_err[d] <= frame_err[d] + 1;
                    end else if (dec_cnt[d] < 9 * baud_of(d)) begin
                        dec_sh[d] <= {tx_v[d], dec_sh[d][7:1]};
                    end else begin
                        if (tx_v[d] !== 1'b1) frame_err[d] <= frame_err[d] + 1;
                        if (rx_n[d] < 400) rx[d][rx_n[d]] <= dec_sh[d];
                        rx_n[d]    <= rx_n[d] + 1;
                        dec_act[d] <= 1'b0;
                    end
                end
            end
        end
        if (re_v[1] === 1'b1 && (!re_prev || addr_v[1] !== adr_prev)) begin
            if (adr_n < 16) adr_log[adr_n] <= addr_v[1];
            adr_n <= adr_n + 1;
        end
        re_prev  <= re_v[1];
        adr_prev <= addr_v[1];
    end

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Raise start for one clock. Returns at the negedge after the sampling edge.
    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit, output int cyc);
        cyc = 0;
        while (done_v[d] !== 1'b1 && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    logic [7:0] exp_a [4] = '{8'h41, 8'h20, 8'h0D, 8'h0A};
    logic [8:0] exp_b [6] = '{9'h000, 9'h001, 9'h002, 9'h020, 9'h021, 9'h022};

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int base, dbase, cyc, w, bad, idx;
        logic [7:0] b, eb;

        for (int d = 0; d < NDUT; d++) begin
            start_v[d] = 1'b0;
            for (int i = 0; i < 512; i++) begin
                if (d == 2) doc[d][i] = (i % 7 == 0) ? 8'h00 : 8'(8'h30 + (i % 40));
                else        doc[d][i] = 8'h42;
            end
        end
        doc[0][0] = 8'h41;
        doc[0][1] = 8'h00;
        doc[3][0] = 8'h41;

        // Reset held for two edges
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst tx",   tx_v[0],   1'b1);
        check("rst busy", busy_v[0], 1'b0);
        check("rst done", done_v[0], 1'b0);
        check("rst re",   re_v[0],   1'b0);
        check("rst addr", addr_v[0], 9'h000);
        check("rst tx default inst", tx_v[3], 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Dump of a 1x2 document: 41 20 0D 0A
        base  = rx_n[0];
        dbase = done_n[0];
        pulse_start(0);
        check("A re in fetch",    re_v[0],   1'b1);
        check("A busy in fetch",  busy_v[0], 1'b1);
        check("A tx idle fetch",  tx_v[0],   1'b1);
        check("A addr first",     addr_v[0], 9'h000);
        @(negedge clk);
        check("A first start bit", tx_v[0], 1'b0);
        wait_done(0, 400, cyc);
        check("A done latency", cyc + 2, 163);
        @(negedge clk);
        check("A busy after", busy_v[0], 1'b0);
        check("A re after",   re_v[0],   1'b0);
        check("A done width", done_v[0], 1'b0);
        repeat (4) @(negedge clk);
        check("A frame count", rx_n[0] - base, 4);
        for (int i = 0; i < 4; i++) check($sformatf("A byte%0d", i), rx[0][base + i], exp_a[i]);
        check("A done count", done_n[0] - dbase, 1);
        check("A framing", frame_err[0], 0);

        // A start pulse in the middle of the second frame has no effect
        base  = rx_n[0];
        dbase = done_n[0];
        pulse_start(0);
        repeat (58) @(negedge clk);
        check("A busy mid dump", busy_v[0], 1'b1);
        pulse_start(0);
        wait_done(0, 400, cyc);
        check("A latency w/ extra start", cyc + 60, 163);
        repeat (60) @(negedge clk);
        check("A no restart busy", busy_v[0], 1'b0);
        check("A frames w/ extra start", rx_n[0] - base, 4);
        check("A done once w/ extra start", done_n[0] - dbase, 1);

        // Reset during a data bit abandons the frame
        pulse_start(0);
        @(negedge clk);
        repeat (9) @(negedge clk);
        check("A in data bit", tx_v[0], 1'b0);
        dbase = done_n[0];
        rst = 1'b1;
        @(negedge clk);
        check("A mid rst tx",   tx_v[0],   1'b1);
        check("A mid rst busy", busy_v[0], 1'b0);
        check("A mid rst re",   re_v[0],   1'b0);
        check("A mid rst addr", addr_v[0], 9'h000);
        rst = 1'b0;
        @(negedge clk);
        check("A no done after rst", done_n[0] - dbase, 0);
        base = rx_n[0];
        pulse_start(0);
        check("A restart addr", addr_v[0], 9'h000);
        wait_done(0, 400, cyc);
        check("A restart latency", cyc + 1, 163);
        repeat (4) @(negedge clk);
        check("A restart frames", rx_n[0] - base, 4);
        for (int i = 0; i < 4; i++) check($sformatf("A restart byte%0d", i), rx[0][base + i], exp_a[i]);

        // Address walk on a 2x3 document
        pulse_start(1);
        wait_done(1, 1000, cyc);
        check("B done latency", cyc + 1, 407);
        repeat (4) @(negedge clk);
        check("B addr count", adr_n, 6);
        for (int i = 0; i < 6; i++) check($sformatf("B addr%0d", i), adr_log[i], exp_b[i]);
        check("B frames", rx_n[1], 10);
        check("B CR row0", rx[1][3], 8'h0D);
        check("B LF row1", rx[1][9], 8'h0A);

        // Full 15x20 document: 330 frames
        pulse_start(2);
        wait_done(2, 20000, cyc);
        check("C done latency", cyc + 1, 13501);
        repeat (4) @(negedge clk);
        check("C frame count", rx_n[2], 330);
        bad = 0;
        idx = 0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 20; c++) begin
                b  = doc[2][r * 32 + c];
                eb = (b == 8'h00) ? 8'h20 : b;
                if (rx[2][idx] !== eb) bad++;
                idx++;
            end
            if (rx[2][idx] !== 8'h0D) bad++;
            idx++;
            if (rx[2][idx] !== 8'h0A) bad++;
            idx++;
        end
        check("C stream bytes", bad, 0);
        check("C framing", frame_err[2], 0);
        check("C done count", done_n[2], 1);

        // Default parameters: every bit lasts 868 cycles
        pulse_start(3);
        w = 0;
        while (tx_v[3] !== 1'b0 && w < 10) begin @(negedge clk); w++; end
        check("D start delay", w, 1);
        w = 0;
        while (tx_v[3] === 1'b0 && w < 2000) begin @(negedge clk); w++; end
        check("D start bit width", w, 868);
        w = 0;
        while (tx_v[3] === 1'b1 && w < 2000) begin @(negedge clk); w++; end
        check("D data bit0 width", w, 868);
        check("D data bit1", tx_v[3], 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("D rst tx",   tx_v[3],   1'b1);
        check("D rst busy", busy_v[3], 1'b0);
        check("D no done",  done_n[3], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
